// File: rtl/rshift_pkg.sv
// Shared types and helpers for the sequential right shifter.
package rshift_pkg;

  localparam int unsigned RSHIFT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Shift-amount width for a given operand width; never narrower than one bit.
  function automatic int unsigned calc_sw(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 mux cell: y = sel ? b : a.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/rshift_stage.sv
// One-bit right-shift stage built from mux2to1 cells; fill drives the vacated MSB.
module rshift_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  input  logic             fill,
  input  logic             en,
  output logic [WIDTH-1:0] q_c
);

  logic [WIDTH-1:0] upper;

  assign upper = {fill, d[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2to1 u_mux (
      .a   (d[i]),
      .b   (upper[i]),
      .sel (en),
      .y   (q_c[i])
    );
  end

endmodule

// File: rtl/rshift_seq.sv
// Multi-cycle right shifter: one bit per clock, result presented with a done strobe.
// Optional build macro RSHIFT_ASR_EN adds an arith input selecting sign fill.
module rshift_seq
  import rshift_pkg::*;
#(
  parameter int unsigned WIDTH = RSHIFT_WIDTH,
  parameter int unsigned SW    = calc_sw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SW-1:0]    shr,
`ifdef RSHIFT_ASR_EN
  input  logic             arith,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] OUT
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    cnt_q;
  logic             fill_q;
  logic             fill_in;
  logic             load_c;
  logic             out_load_c;
  logic             shift_en_c;
  logic [WIDTH-1:0] stage_q_c;

  // Fill bit is frozen at accept so a later A change cannot alter the result.
`ifdef RSHIFT_ASR_EN
  assign fill_in = arith & A[WIDTH-1];
`else
  assign fill_in = 1'b0;
`endif

  assign shift_en_c = (state_q == ST_SHIFT) && (cnt_q != '0);

  rshift_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .d    (data_q),
    .fill (fill_q),
    .en   (shift_en_c),
    .q_c  (stage_q_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    out_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          out_load_c = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      OUT    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (load_c) begin
        data_q <= A;
        cnt_q  <= shr;
        fill_q <= fill_in;
      end else if (shift_en_c) begin
        data_q <= stage_q_c;
        cnt_q  <= cnt_q - SW'(1);
      end
      if (out_load_c) begin
        OUT <= data_q;
      end
      busy <= (state_d == ST_SHIFT);
      done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rshift_seq.sv
// Directed bench for rshift_seq: reset, latency, sweep, back-to-back, ignored start.
module tb_rshift_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [1:0] shr;
`ifdef RSHIFT_ASR_EN
  logic       arith;
`endif
  logic       busy;
  logic       done;
  logic [3:0] OUT;

  int total = 0;
  int bad   = 0;

  rshift_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .shr   (shr),
`ifdef RSHIFT_ASR_EN
    .arith (arith),
`endif
    .busy  (busy),
    .done  (done),
    .OUT   (OUT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one op, wait (bounded) for done, check busy length and result, then idle one cycle.
  task automatic do_op(input logic [3:0] a, input logic [1:0] s, input logic [3:0] exp,
                       input string tag);
    int nbusy;
    int guard;
    int overlap;
    A = a; shr = s; start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0; guard = 0; overlap = 0;
    while (!done && guard < 20) begin
      if (busy) nbusy++;
      tick();
      guard++;
    end
    if (busy && done) overlap = 1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busycycles"}, 32'(nbusy), 32'(s) + 32'd1);
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_out"}, 32'(OUT), 32'(exp));
    tick();
    check({tag, "_strobe"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(OUT), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 4'd0; shr = 2'd0;
`ifdef RSHIFT_ASR_EN
    arith = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_out", 32'(OUT), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // shr=0: one busy cycle, done next.
    do_op(4'b1011, 2'd0, 4'b1011, "shr0");
    // shr=3: only A[3] survives.
    do_op(4'b1011, 2'd3, 4'b0001, "shr3");
    do_op(4'b1100, 2'd1, 4'b0110, "c1");
    do_op(4'b1111, 2'd2, 4'b0011, "c2");

    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < 4; s++) begin
        do_op(4'(a), 2'(s), 4'(a) >> s, $sformatf("sweep_a%0d_s%0d", a, s));
      end
    end

    // Back-to-back: start held through DONE, second operands set during SHIFT.
    A = 4'b1100; shr = 2'd1; start = 1'b1;
    tick();
    A = 4'b0110; shr = 2'd2;
    check("b2b_busy0", 32'(busy), 32'd1);
    tick();
    tick();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_out1", 32'(OUT), 32'b0110);
    tick();
    start = 1'b0;
    check("b2b_noidle", 32'(busy), 32'd1);
    tick();
    tick();
    check("b2b_busy_still", 32'(busy), 32'd1);
    tick();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_out2", 32'(OUT), 32'b0001);
    tick();

    // start pulsed mid-shift with different operands is ignored.
    A = 4'b1011; shr = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'b0000; shr = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_hold", 32'(OUT), 32'b0001);
    tick();
    tick();
    check("ign_done", 32'(done), 32'd1);
    check("ign_out", 32'(OUT), 32'b0001);
    tick();
    tick();
    check("ign_idle", 32'(busy), 32'd0);
    check("ign_hold2", 32'(OUT), 32'b0001);

    // Reset mid-SHIFT abandons the op.
    A = 4'b1010; shr = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", 32'(OUT), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("midrst_nodone%0d", i), 32'(done | busy), 32'd0);
    end

    // rst and start together: rst wins.
    rst = 1'b1; start = 1'b1; A = 4'b1111; shr = 2'd1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rststart_busy", 32'(busy), 32'd0);
    tick();
    check("rststart_idle", 32'(busy | done), 32'd0);

`ifdef RSHIFT_ASR_EN
    arith = 1'b1;
    do_op(4'b1000, 2'd2, 4'b1110, "asr1");
    arith = 1'b0;
    do_op(4'b1000, 2'd2, 4'b0010, "asr0");
    arith = 1'b1;
    do_op(4'b0100, 2'd1, 4'b0010, "asr_pos");
    arith = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
